tick_monitor: RTL and testbench

TICK_MONITOR -- requirements
Module: tick_monitor

---
 rtl/tick_monitor_if.sv | 27 ++
 rtl/tick_monitor.sv | 136 +++++++++++++
 tb/tb_tick_monitor.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : tick_monitor_if
//  Brief    : Pulse input and measurement/status outputs of tick_monitor.
//  Revision : 1.0  initial release
// ============================================================================
interface tick_monitor_if;
    logic        pulse_in;
    logic [11:0] period;
    logic        period_valid;
    logic        err_early;
    logic        err_late;
    logic        lock;
    logic        lost;
    logic [15:0] tick_cnt;

    modport master (
        output pulse_in,
        input  period, period_valid, err_early, err_late, lock, lost, tick_cnt
    );

    modport slave (
        input  pulse_in,
        output period, period_valid, err_early, err_late, lock, lost, tick_cnt
    );
endinterface
`default_nettype wire

// File: rtl/tick_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tick_monitor
//  Brief    : Measures the interval between periodic ticks, flags early/late
//             ticks and reports lock / loss of the tick stream.
//  Revision : 1.0  initial release
// ============================================================================
module tick_monitor #(
    parameter int EXPECT = 2401,
    parameter int TOL    = 4,
    parameter int LOCK_N = 3
) (
    input  wire logic     clk_in,
    input  wire logic     reset,
    tick_monitor_if.slave bus
);

    localparam int                 C_RUN_W    = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [11:0]        C_LATE_CNT = 12'(EXPECT + TOL - 1);
    localparam logic [12:0]        C_MIN_IVL  = 13'(EXPECT - TOL);
    localparam logic [C_RUN_W-1:0] C_LOCK_RUN = C_RUN_W'(LOCK_N);

    if ((EXPECT + TOL > 4095) || (TOL >= EXPECT) || (TOL < 0) || (LOCK_N < 1)) begin : g_param_check
        $error("tick_monitor: illegal EXPECT/TOL/LOCK_N combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_LOST  = 2'd2
    } state_t;

    state_t               r_state,        w_state;
    logic [11:0]          r_cnt,          w_cnt;
    logic [C_RUN_W-1:0]   r_good_run,     w_good_run;
    logic [11:0]          r_period,       w_period;
    logic                 r_period_valid, w_period_valid;
    logic                 r_err_early,    w_err_early;
    logic                 r_err_late,     w_err_late;
    logic                 r_lock,         w_lock;
    logic                 r_lost,         w_lost;
    logic [15:0]          r_tick_cnt,     w_tick_cnt;
    logic [12:0]          w_interval;

    // Timeout in TRACK keeps cnt below EXPECT+TOL, so the interval never overflows 12 bits there.
    assign w_interval = {1'b0, r_cnt} + 13'd1;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_good_run     <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_err_early    <= 1'b0;
            r_err_late     <= 1'b0;
            r_lock         <= 1'b0;
            r_lost         <= 1'b0;
            r_tick_cnt     <= '0;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_good_run     <= w_good_run;
            r_period       <= w_period;
            r_period_valid <= w_period_valid;
            r_err_early    <= w_err_early;
            r_err_late     <= w_err_late;
            r_lock         <= w_lock;
            r_lost         <= w_lost;
            r_tick_cnt     <= w_tick_cnt;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_cnt          = bus.pulse_in ? 12'd0 : ((r_cnt == 12'hFFF) ? r_cnt : r_cnt + 12'd1);
        w_good_run     = r_good_run;
        w_period       = r_period;
        w_period_valid = 1'b0;
        w_err_early    = 1'b0;
        w_err_late     = 1'b0;
        w_lock         = r_lock;
        w_lost         = r_lost;
        w_tick_cnt     = r_tick_cnt;

        case (r_state)
            S_IDLE: begin
                if (bus.pulse_in) begin
                    w_state = S_TRACK;
                end
            end
            S_TRACK: begin
                if (bus.pulse_in) begin
                    w_period       = w_interval[11:0];
                    w_period_valid = 1'b1;
                    if (w_interval < C_MIN_IVL) begin
                        w_err_early = 1'b1;
                        w_lock      = 1'b0;
                        w_good_run  = '0;
                    end else begin
                        w_tick_cnt = r_tick_cnt + 16'd1;
                        if (r_good_run != C_LOCK_RUN) begin
                            w_good_run = r_good_run + 1'b1;
                        end
                        w_lock = (w_good_run == C_LOCK_RUN);
                    end
                end else if (r_cnt == C_LATE_CNT) begin
                    w_err_late = 1'b1;
                    w_lock     = 1'b0;
                    w_good_run = '0;
                    w_lost     = 1'b1;
                    w_state    = S_LOST;
                end
            end
            S_LOST: begin
                if (bus.pulse_in) begin
                    w_state = S_TRACK;
                    w_lost  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.err_early    = r_err_early;
    assign bus.err_late     = r_err_late;
    assign bus.lock         = r_lock;
    assign bus.lost         = r_lost;
    assign bus.tick_cnt     = r_tick_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tick_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_monitor
//  Brief    : Directed self-checking bench for tick_monitor (default params).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_monitor;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    tick_monitor_if bus ();

    tick_monitor #(
        .EXPECT (2401),
        .TOL    (4),
        .LOCK_N (3)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;
    int pv_seen   = 0;
    int late_seen = 0;

    // Observed state packed as {pv, early, late, lock, lost, period[11:0], tick_cnt[15:0]}
    logic [32:0] obs;
    assign obs = {bus.period_valid, bus.err_early, bus.err_late, bus.lock, bus.lost,
                  bus.period, bus.tick_cnt};

    always @(posedge clk_in) begin
        if (bus.period_valid === 1'b1) pv_seen   <= pv_seen + 1;
        if (bus.err_late === 1'b1)     late_seen <= late_seen + 1;
    end

    task automatic idle(input int n);
        bus.pulse_in = 1'b0;
        repeat (n) @(negedge clk_in);
    endtask

    task automatic pulse();
        bus.pulse_in = 1'b1;
        @(negedge clk_in);
        bus.pulse_in = 1'b0;
    endtask

    // Pulse sampled n cycles after the previous pulse.
    task automatic gap_pulse(input int n);
        idle(n - 1);
        pulse();
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        reset = 1'b1;
        bus.pulse_in = 1'b1;
        repeat (3) @(negedge clk_in);
        exp = {5'b00000, 12'd0, 16'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_state: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        reset = 1'b0;
        bus.pulse_in = 1'b0;
    endtask

    task automatic test_lock();
        logic [32:0] exp;
        int pv0;
        pv0 = pv_seen;
        idle(3);
        pulse();
        exp = {5'b00000, 12'd0, 16'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL lock_arm: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        for (int i = 1; i <= 4; i++) begin
            gap_pulse(2401);
            exp = {1'b1, 1'b0, 1'b0, (i >= 3), 1'b0, 12'd2401, 16'(i)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL lock_interval%0d: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                         i, obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
            end
        end
        idle(1);
        n_cmp++;
        if (pv_seen - pv0 !== 4) begin
            n_bad++;
            $display("FAIL lock_pv_count: got %0d want 4", pv_seen - pv0);
        end
    endtask

    task automatic test_early();
        logic [32:0] exp;
        // Previous pulse was 1 idle cycle ago; a 2000 interval needs 1998 more idles.
        idle(1998);
        pulse();
        exp = {5'b11000, 12'd2000, 16'd4};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL early_2000: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        for (int i = 1; i <= 3; i++) begin
            gap_pulse(2401);
            exp = {1'b1, 1'b0, 1'b0, (i == 3), 1'b0, 12'd2401, 16'(4 + i)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL early_relock%0d: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                         i, obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp;
        idle(1000);
        reset = 1'b1;
        bus.pulse_in = 1'b1;
        @(negedge clk_in);
        reset = 1'b0;
        bus.pulse_in = 1'b0;
        exp = {5'b00000, 12'd0, 16'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL midreset_clear: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        idle(499);
        pulse();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL midreset_arm: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        gap_pulse(2401);
        exp = {5'b10000, 12'd2401, 16'd1};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL midreset_first: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
    endtask

    task automatic test_boundaries();
        logic [32:0] exp;
        gap_pulse(2397);
        exp = {5'b10000, 12'd2397, 16'd2};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL bound_2397: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        gap_pulse(2405);
        exp = {5'b10010, 12'd2405, 16'd3};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL bound_2405: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        gap_pulse(2396);
        exp = {5'b11000, 12'd2396, 16'd3};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL bound_2396: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        for (int i = 0; i < 2; i++) begin
            gap_pulse(1);
            exp = {5'b11000, 12'd1, 16'd3};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b_%0d: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                         i, obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [32:0] exp;
        int late0;
        for (int i = 1; i <= 3; i++) begin
            gap_pulse(2401);
            exp = {1'b1, 1'b0, 1'b0, (i == 3), 1'b0, 12'd2401, 16'(3 + i)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL tmo_lock%0d: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                         i, obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
            end
        end
        late0 = late_seen;
        idle(2404);
        exp = {5'b00010, 12'd2401, 16'd6};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_before: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        idle(1);
        exp = {5'b00101, 12'd2401, 16'd6};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_strobe: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        idle(1);
        exp = {5'b00001, 12'd2401, 16'd6};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_lost: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        idle(100);
        pulse();
        exp = {5'b00000, 12'd2401, 16'd6};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_recover: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        n_cmp++;
        if (late_seen - late0 !== 1) begin
            n_bad++;
            $display("FAIL tmo_late_count: got %0d want 1", late_seen - late0);
        end
        gap_pulse(2401);
        exp = {5'b10000, 12'd2401, 16'd7};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL tmo_retrack: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
    endtask

    task automatic test_wrap();
        logic [32:0] exp;
        force dut.r_tick_cnt = 16'hFFFF;
        idle(1);
        release dut.r_tick_cnt;
        idle(2399);
        exp = {5'b00000, 12'd2401, 16'd65535};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL wrap_preload: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
        pulse();
        exp = {5'b10000, 12'd2401, 16'd0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL wrap_zero: got flags=%b period=%0d tick=%0d want flags=%b period=%0d tick=%0d",
                     obs[32:28], obs[27:16], obs[15:0], exp[32:28], exp[27:16], exp[15:0]);
        end
    endtask

    initial begin
        bus.pulse_in = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_lock();
        test_early();
        test_reset_mid();
        test_boundaries();
        test_back_to_back();
        test_timeout();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
